mem_stage_bus: RTL

Memory-stage load/store unit that drives an external data memory through a valid/ready request/response bus with arbitrary latency. It generalises the single-cycle memory stage with a parametrised data/address width, a multi-cycle FSM, a pipeline stall output, misalignment and access-fault exceptions, and a response timeout. It sits between the execute/memory pipeline register and the writeback stage.

---
 rtl/mem_stage_bus.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_bus.sv
// mem_stage_bus: memory-stage load/store unit driving an external data memory
// over a valid/ready request bus and a strobed response bus of any latency.
//
// Ports
//   clk, arst_n                      clock, async active-low reset
//   req_valid_in, is_store, lsuop,   memory op from the EX/MEM register
//   addr, store_data, rd_in          (held stable while stall_out=1)
//   stall_out                        hold the pipeline
//   bus_req_*                        registered request, live only in REQ
//   bus_rsp_valid/rdata/err          response strobe (acks writes as well)
//   load_valid/load_data/load_rd     one-cycle load writeback pulse
//   exc_valid/exc_cause/exc_addr     one-cycle exception pulse
//                                    (0 ld misalign, 1 st misalign,
//                                     2 ld fault, 3 st fault)
module mem_stage_bus #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    req_valid_in,
  input  logic                    is_store,
  input  logic [2:0]              lsuop,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   store_data,
  input  logic [4:0]              rd_in,
  output logic                    stall_out,
  output logic                    bus_req_valid,
  input  logic                    bus_req_ready,
  output logic [ADDR_WIDTH-1:0]   bus_req_addr,
  output logic                    bus_req_we,
  output logic [DATA_WIDTH/8-1:0] bus_req_mask,
  output logic [DATA_WIDTH-1:0]   bus_req_wdata,
  input  logic                    bus_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   bus_rsp_rdata,
  input  logic                    bus_rsp_err,
  output logic                    load_valid,
  output logic [DATA_WIDTH-1:0]   load_data,
  output logic [4:0]              load_rd,
  output logic                    exc_valid,
  output logic [1:0]              exc_cause,
  output logic [ADDR_WIDTH-1:0]   exc_addr
);
  localparam int DW   = DATA_WIDTH;
  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;
  state_t state;

  // latched operation
  logic                  lat_store;
  logic [2:0]            lat_op;
  logic [OFFW-1:0]       lat_off;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [4:0]            lat_rd;
  logic [TW-1:0]         tmo_cnt;

  // ---- request-side decode (from live inputs, used in IDLE) ----
  logic [OFFW-1:0] in_off;
  logic [1:0]      in_sz;
  logic            in_legal, in_misal;
  logic [NB-1:0]   mask_c;
  logic [DW-1:0]   wdata_c;

  assign in_off   = addr[OFFW-1:0];
  assign in_sz    = lsuop[1:0];
  // offset must be a multiple of 1<<in_sz
  assign in_misal = |(in_off & OFFW'((1 << in_sz) - 1));

  always_comb begin
    case (lsuop)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: in_legal = 1'b1;
      3'b011, 3'b110:                         in_legal = (DATA_WIDTH == 64);
      default:                                in_legal = 1'b0;
    endcase
  end

  // Loads fetch the whole bus word and extract locally, so only stores
  // narrow the byte-lane mask.
  always_comb begin
    mask_c = '1;
    if (is_store) begin
      case (in_sz)
        2'd0:    mask_c = NB'(1)  << in_off;
        2'd1:    mask_c = NB'(3)  << in_off;
        2'd2:    mask_c = NB'(15) << in_off;
        default: mask_c = '1;
      endcase
    end
  end

  // Store data is replicated to every lane; the mask picks the live one.
  always_comb begin
    wdata_c = '0;
    if (is_store) begin
      case (in_sz)
        2'd0:    for (int i = 0; i < NB;   i++) wdata_c[i*8  +: 8]  = store_data[7:0];
        2'd1:    for (int i = 0; i < NB/2; i++) wdata_c[i*16 +: 16] = store_data[15:0];
        2'd2:    for (int i = 0; i < NB/4; i++) wdata_c[i*32 +: 32] = store_data[31:0];
        default: wdata_c = store_data;
      endcase
    end
  end

  // ---- response-side load extract ----
  logic [DW-1:0] rsp_sh, ld_c;
  assign rsp_sh = bus_rsp_rdata >> {lat_off, 3'b000};

  always_comb begin
    case (lat_op)
      3'b000:  ld_c = DW'($signed(rsp_sh[7:0]));
      3'b001:  ld_c = DW'($signed(rsp_sh[15:0]));
      3'b010:  ld_c = DW'($signed(rsp_sh[31:0]));
      3'b100:  ld_c = DW'(rsp_sh[7:0]);
      3'b101:  ld_c = DW'(rsp_sh[15:0]);
      3'b110:  ld_c = DW'(rsp_sh[31:0]);
      default: ld_c = rsp_sh;
    endcase
  end

  assign stall_out = ((state == IDLE) && req_valid_in) || (state == REQ) || (state == RSP);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state         <= IDLE;
      lat_store     <= 1'b0;
      lat_op        <= '0;
      lat_off       <= '0;
      lat_addr      <= '0;
      lat_rd        <= '0;
      tmo_cnt       <= '0;
      bus_req_valid <= 1'b0;
      bus_req_addr  <= '0;
      bus_req_we    <= 1'b0;
      bus_req_mask  <= '0;
      bus_req_wdata <= '0;
      load_valid    <= 1'b0;
      load_data     <= '0;
      load_rd       <= '0;
      exc_valid     <= 1'b0;
      exc_cause     <= '0;
      exc_addr      <= '0;
    end else begin
      load_valid <= 1'b0;
      exc_valid  <= 1'b0;
      case (state)
        IDLE: if (req_valid_in) begin
          lat_store <= is_store;
          lat_op    <= lsuop;
          lat_off   <= in_off;
          lat_addr  <= addr;
          lat_rd    <= rd_in;
          if (!in_legal || in_misal) begin
            // illegal encodings share the misaligned cause
            state     <= DONE;
            exc_valid <= 1'b1;
            exc_cause <= {1'b0, is_store};
            exc_addr  <= addr;
          end else begin
            state         <= REQ;
            bus_req_valid <= 1'b1;
            bus_req_addr  <= {addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
            bus_req_we    <= is_store;
            bus_req_mask  <= mask_c;
            bus_req_wdata <= wdata_c;
          end
        end
        REQ: if (bus_req_ready) begin
          state         <= RSP;
          tmo_cnt       <= '0;
          bus_req_valid <= 1'b0;
          bus_req_addr  <= '0;
          bus_req_we    <= 1'b0;
          bus_req_mask  <= '0;
          bus_req_wdata <= '0;
        end
        RSP: begin
          if (bus_rsp_valid) begin
            // a response in the timeout cycle still counts as a response
            state <= DONE;
            if (bus_rsp_err) begin
              exc_valid <= 1'b1;
              exc_cause <= {1'b1, lat_store};
              exc_addr  <= lat_addr;
            end else if (!lat_store) begin
              load_valid <= 1'b1;
              load_data  <= ld_c;
              load_rd    <= lat_rd;
            end
          end else begin
            if (tmo_cnt != TW'(TIMEOUT_CYCLES)) tmo_cnt <= tmo_cnt + TW'(1);
            // this cycle is the TIMEOUT_CYCLES-th one without a response
            if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
              state     <= DONE;
              exc_valid <= 1'b1;
              exc_cause <= {1'b1, lat_store};
              exc_addr  <= lat_addr;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
